// File: rtl/keccak_miner_pkg.sv
// Shared definitions for the keccak nonce scanner and its result FIFO.
//   NONCE_W      : nonce / target width
//   HDR_W        : block header width, excluding the nonce
//   scan_state_e : scanner FSM states
package keccak_miner_pkg;

    localparam int NONCE_W = 32;
    localparam int HDR_W   = 608;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/gn_result_fifo.sv
// Synchronous FIFO holding golden nonces until the consumer takes them.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_data (accepted when not full, or when full and popping)
//   i_data     : nonce to store
//   i_pop      : remove the oldest entry (ignored when empty)
//   o_data     : oldest entry, zero while empty
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
module gn_result_fifo
    import keccak_miner_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [NONCE_W-1:0] i_data,
    input  logic               i_pop,
    output logic [NONCE_W-1:0] o_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [NONCE_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               w_do_pop;
    logic               w_do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Storage is unreset, so the output is forced to zero while nothing valid is held.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: data storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/keccak_nonce_scanner.sv
// Nonce-range controller for NUM_CORES pipelined keccak cores.
//   start/abort          : job control pulses
//   header/target        : job data, latched on an accepted start
//   nonce_start/end      : inclusive nonce range
//   core_header/target   : latched job data to the cores
//   core_nonce           : lane i nonce in bits [32i+31:32i]
//   core_match           : lane hits, CORE_LAT cycles after issue
//   busy/done            : SCAN|DRAIN / one-cycle end-of-job pulse
//   res_valid/ready/nonce: golden-nonce result port
//   res_dropped          : saturating count of lost hits
module keccak_nonce_scanner
    import keccak_miner_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int CORE_LAT   = 25,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [HDR_W-1:0]               header,
    input  logic [NONCE_W-1:0]             nonce_start,
    input  logic [NONCE_W-1:0]             nonce_end,
    input  logic [NONCE_W-1:0]             target,
    output logic [HDR_W-1:0]               core_header,
    output logic [NONCE_W-1:0]             core_target,
    output logic [NONCE_W*NUM_CORES-1:0]   core_nonce,
    input  logic [NUM_CORES-1:0]           core_match,
    output logic                           busy,
    output logic                           done,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [NONCE_W-1:0]             res_nonce,
    output logic [7:0]                     res_dropped
);

    localparam int CNT_W  = $clog2(CORE_LAT + 1);
    localparam int LANE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    scan_state_e                  r_state, w_next_state;
    logic [HDR_W-1:0]             r_header;
    logic [NONCE_W-1:0]           r_target;
    logic [NONCE_W-1:0]           r_end;
    logic [NONCE_W:0]             r_base;          // 33 bits: range end at 2^32-1 cannot wrap
    logic [CNT_W-1:0]             r_drain_cnt;
    logic [NONCE_W*NUM_CORES-1:0] r_core_nonce;
    logic [NONCE_W-1:0]           r_issue_base;
    logic [NUM_CORES-1:0]         r_issue_mask;
    logic [NONCE_W-1:0]           r_dl_base [CORE_LAT];
    logic [NUM_CORES-1:0]         r_dl_mask [CORE_LAT];
    logic [7:0]                   r_dropped;

    logic                         w_start_ok, w_abort_ok, w_issue, w_last_group;
    logic [NONCE_W*NUM_CORES-1:0] w_issue_nonce;
    logic [NUM_CORES-1:0]         w_lane_mask, w_hits;
    logic [NONCE_W:0]             w_sum;
    logic [LANE_W-1:0]            w_hit_lane;
    logic                         w_any_hit, w_pop, w_push_ok, w_fifo_full, w_fifo_empty;
    logic [7:0]                   w_num_hits, w_drop_inc;
    logic [8:0]                   w_drop_sum;
    logic [NONCE_W-1:0]           w_hit_nonce;

    assign w_start_ok   = start & (r_state == IDLE);
    assign w_abort_ok   = abort & busy;
    assign w_issue      = (r_state == SCAN) & ~abort;
    assign w_last_group = (r_base + (NONCE_W+1)'(NUM_CORES)) > {1'b0, r_end};

    // NOTE: every variable gets a default at the top of an always_comb so no latch is inferred.
    always_comb begin
        w_issue_nonce = '0;
        w_lane_mask   = '0;
        w_sum         = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_sum = r_base + (NONCE_W+1)'(i);
            w_issue_nonce[i*NONCE_W +: NONCE_W] = w_sum[NONCE_W-1:0];
            w_lane_mask[i] = (w_sum <= {1'b0, r_end});
        end
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (start) w_next_state = (nonce_start > nonce_end) ? DONE : SCAN;
            SCAN:  if (abort) w_next_state = IDLE;
                   else if (w_last_group) w_next_state = DRAIN;
            DRAIN: if (abort) w_next_state = IDLE;
                   else if (r_drain_cnt == '0) w_next_state = DONE;
            DONE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state == SCAN) || (r_state == DRAIN);
        done = (r_state == DONE);
    end

    // ---------------- Job latch and nonce issue ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_header     <= '0;
            r_target     <= '0;
            r_end        <= '0;
            r_base       <= '0;
            r_core_nonce <= '0;
            r_issue_base <= '0;
            r_issue_mask <= '0;
            r_drain_cnt  <= '0;
        end else begin
            if (w_start_ok) begin
                r_header <= header;
                r_target <= target;
                r_end    <= nonce_end;
                r_base   <= {1'b0, nonce_start};
            end else if (w_issue) begin
                r_base <= r_base + (NONCE_W+1)'(NUM_CORES);
            end
            // core_nonce holds its last value outside SCAN; the mask says whether it is live.
            if (w_issue) begin
                r_core_nonce <= w_issue_nonce;
                r_issue_base <= r_base[NONCE_W-1:0];
                r_issue_mask <= w_lane_mask;
            end else begin
                r_issue_mask <= '0;
            end
            // Counts CORE_LAT..0 so the last group's match is still sampled in DRAIN.
            if (w_issue && w_last_group)                      r_drain_cnt <= CNT_W'(CORE_LAT);
            else if (r_state == DRAIN && r_drain_cnt != '0)   r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    // ---------------- Delay line: stage k holds the group issued k+1 cycles ago ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CORE_LAT; k++) begin
                r_dl_base[k] <= '0;
                r_dl_mask[k] <= '0;
            end
        end else begin
            r_dl_base[0] <= r_issue_base;
            r_dl_mask[0] <= w_abort_ok ? '0 : r_issue_mask;
            for (int k = 1; k < CORE_LAT; k++) begin
                r_dl_base[k] <= r_dl_base[k-1];
                r_dl_mask[k] <= w_abort_ok ? '0 : r_dl_mask[k-1];
            end
        end
    end

    // ---------------- Hit selection: lowest lane wins ----------------
    assign w_hits = core_match & r_dl_mask[CORE_LAT-1];

    always_comb begin
        w_hit_lane = '0;
        w_any_hit  = 1'b0;
        w_num_hits = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_hits[i]) begin
                w_num_hits = w_num_hits + 8'd1;
                if (!w_any_hit) begin
                    w_hit_lane = LANE_W'(i);
                    w_any_hit  = 1'b1;
                end
            end
        end
    end

    assign w_hit_nonce = r_dl_base[CORE_LAT-1] + NONCE_W'(w_hit_lane);
    assign w_pop       = res_ready & ~w_fifo_empty;
    assign w_push_ok   = w_any_hit & (~w_fifo_full | w_pop);
    assign w_drop_inc  = w_num_hits - {7'd0, w_push_ok};
    assign w_drop_sum  = {1'b0, r_dropped} + {1'b0, w_drop_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_dropped <= '0;
        else if (w_start_ok) r_dropped <= '0;
        else                 r_dropped <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end

    gn_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_any_hit),
        .i_data  (w_hit_nonce),
        .i_pop   (res_ready),
        .o_data  (res_nonce),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign res_valid   = ~w_fifo_empty;
    assign res_dropped = r_dropped;
    assign core_header = r_header;
    assign core_target = r_target;
    assign core_nonce  = r_core_nonce;

endmodule

// File: tb/tb_keccak_nonce_scanner.sv
// Self-checking bench for keccak_nonce_scanner (NUM_CORES=2, CORE_LAT=25, FIFO_DEPTH=4).
// A behavioural core array answers each issued nonce CORE_LAT cycles later.
module tb_keccak_nonce_scanner;
    import keccak_miner_pkg::*;

    localparam int NUM_CORES  = 2;
    localparam int CORE_LAT   = 25;
    localparam int FIFO_DEPTH = 4;

    logic                         clk, rst_n, start, abort, res_ready;
    logic [HDR_W-1:0]             header;
    logic [NONCE_W-1:0]           nonce_start, nonce_end, target;
    logic [HDR_W-1:0]             core_header;
    logic [NONCE_W-1:0]           core_target;
    logic [NONCE_W*NUM_CORES-1:0] core_nonce;
    logic [NUM_CORES-1:0]         core_match;
    logic                         busy, done, res_valid;
    logic [NONCE_W-1:0]           res_nonce;
    logic [7:0]                   res_dropped;

    int n_tests = 0;
    int n_fail  = 0;

    keccak_nonce_scanner #(
        .NUM_CORES(NUM_CORES), .CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .header(header),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .core_header(core_header), .core_target(core_target), .core_nonce(core_nonce),
        .core_match(core_match), .busy(busy), .done(done), .res_valid(res_valid),
        .res_ready(res_ready), .res_nonce(res_nonce), .res_dropped(res_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Behavioural core array ----------------
    logic [31:0] hit_lo = 32'd1, hit_hi = 32'd0, hit_extra = 32'd0;
    logic        hit_extra_en = 1'b0;
    logic [NONCE_W*NUM_CORES-1:0] hist [$];
    logic [NONCE_W*NUM_CORES-1:0] old_group;

    function automatic logic is_hit(input logic [31:0] n);
        return ((n >= hit_lo) && (n <= hit_hi)) || (hit_extra_en && (n == hit_extra));
    endfunction

    initial core_match = '0;
    always @(posedge clk) begin
        #1;
        hist.push_back(core_nonce);
        if (hist.size() > CORE_LAT) begin
            old_group = hist.pop_front();
            for (int i = 0; i < NUM_CORES; i++)
                core_match[i] = is_hit(old_group[i*NONCE_W +: NONCE_W]);
        end
    end

    // ---------------- Helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_hits(input logic [31:0] lo, input logic [31:0] hi,
                            input logic x_en, input logic [31:0] x_val);
        hit_lo = lo; hit_hi = hi; hit_extra_en = x_en; hit_extra = x_val;
    endtask

    // Drives a start pulse; lat = edges from the start cycle until done is seen (0 = timeout).
    task automatic run_job(input logic [31:0] lo, input logic [31:0] hi, output int lat);
        @(posedge clk); #1;
        nonce_start = lo; nonce_end = hi; start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic pop_expect(input string name, input logic [31:0] exp);
        check({name, "_valid"}, 64'(res_valid), 64'd1);
        check(name, 64'(res_nonce), 64'(exp));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    // ---------------- Vector table ----------------
    typedef struct packed {
        logic [31:0]       lo, hi, h_lo, h_hi;
        logic              x_en;
        logic [31:0]       x_val;
        int                exp_n;
        logic [3:0][31:0]  exp_res;
        logic [7:0]        exp_drop;
        int                exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] lo, hi, h_lo, h_hi, input logic x_en,
                                input logic [31:0] x_val, input int n,
                                input logic [31:0] e0, e1, e2, e3,
                                input logic [7:0] drop, input int lat);
        vec_t v;
        v.lo = lo; v.hi = hi; v.h_lo = h_lo; v.h_hi = h_hi; v.x_en = x_en; v.x_val = x_val;
        v.exp_n = n; v.exp_res = {e3, e2, e1, e0}; v.exp_drop = drop; v.exp_lat = lat;
        return v;
    endfunction

    vec_t vecs [6];

    initial begin : main
        int          lat, n_done, n_valid;
        logic [31:0] w32;
        logic [HDR_W-1:0] exp_hdr;

        // latency = 1 (start cycle) + groups + CORE_LAT + 1
        vecs[0] = mk(32'h3682bb00, 32'h3682bb0F, 32'h3682bb08, 32'h3682bb08, 1'b0, 0, 1,
                     32'h3682bb08, 0, 0, 0, 8'd0, 35);
        vecs[1] = mk(32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd0, 1,
                     32'hFFFFFFFF, 0, 0, 0, 8'd0, 29);
        vecs[2] = mk(32'd100, 32'd103, 32'd100, 32'd101, 1'b0, 0, 1,
                     32'd100, 0, 0, 0, 8'd1, 29);
        vecs[3] = mk(32'd0, 32'd7, 32'd0, 32'd7, 1'b0, 0, 4,
                     32'd0, 32'd2, 32'd4, 32'd6, 8'd4, 31);
        vecs[4] = mk(32'd50, 32'd54, 32'd54, 32'd55, 1'b0, 0, 1,
                     32'd54, 0, 0, 0, 8'd0, 30);
        vecs[5] = mk(32'd0, 32'd11, 32'd0, 32'd11, 1'b0, 0, 4,
                     32'd0, 32'd2, 32'd4, 32'd6, 8'd8, 33);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        header = '0; nonce_start = '0; nonce_end = '0; target = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- Reset state ----------------
        check("rst_busy",      64'(busy),        64'd0);
        check("rst_done",      64'(done),        64'd0);
        check("rst_res_valid", 64'(res_valid),   64'd0);
        check("rst_dropped",   64'(res_dropped), 64'd0);
        check("rst_core_nonce",64'(core_nonce),  64'd0);

        // ---------------- Table-driven jobs ----------------
        for (int v = 0; v < 6; v++) begin
            w32     = 32'hC0DE0000 | 32'(v);
            exp_hdr = {19{w32}};
            header  = exp_hdr;
            target  = 32'h00FF0000 + 32'(v);
            set_hits(vecs[v].h_lo, vecs[v].h_hi, vecs[v].x_en, vecs[v].x_val);
            run_job(vecs[v].lo, vecs[v].hi, lat);
            check($sformatf("v%0d_done_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
            header = ~exp_hdr;
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", v), 64'(done), 64'd0);
            check($sformatf("v%0d_busy_after", v), 64'(busy), 64'd0);
            check($sformatf("v%0d_core_header", v), 64'(core_header == exp_hdr), 64'd1);
            check($sformatf("v%0d_core_target", v), 64'(core_target), 64'(32'h00FF0000 + 32'(v)));
            check($sformatf("v%0d_dropped", v), 64'(res_dropped), 64'(vecs[v].exp_drop));
            for (int j = 0; j < vecs[v].exp_n; j++)
                pop_expect($sformatf("v%0d_res%0d", v, j), vecs[v].exp_res[j]);
            check($sformatf("v%0d_empty", v), 64'(res_valid), 64'd0);
        end

        // ---------------- Push and pop together while full ----------------
        set_hits(32'd0, 32'd7, 1'b0, 0);
        run_job(32'd0, 32'd7, lat);
        check("full_fill_lat", 64'(lat), 64'd31);
        set_hits(32'd20, 32'd20, 1'b0, 0);
        @(posedge clk); #1;
        nonce_start = 32'd20; nonce_end = 32'd21; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        check("full_head", 64'(res_nonce), 64'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("full_done", 64'(done), 64'd1);
        check("full_dropped", 64'(res_dropped), 64'd0);
        pop_expect("full_res0", 32'd2);
        pop_expect("full_res1", 32'd4);
        pop_expect("full_res2", 32'd6);
        pop_expect("full_res3", 32'd20);
        check("full_empty", 64'(res_valid), 64'd0);

        // ---------------- Async reset in DRAIN ----------------
        header = {19{32'h5A5A1234}};
        target = 32'h12345678;
        set_hits(32'd4, 32'd7, 1'b0, 0);
        @(posedge clk); #1;
        nonce_start = 32'd4; nonce_end = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        check("drain_busy",    64'(busy),        64'd1);
        check("drain_dropped", 64'(res_dropped), 64'd1);
        check("drain_res",     64'(res_nonce),   64'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",        64'(busy),        64'd0);
        check("arst_done",        64'(done),        64'd0);
        check("arst_res_valid",   64'(res_valid),   64'd0);
        check("arst_res_nonce",   64'(res_nonce),   64'd0);
        check("arst_dropped",     64'(res_dropped), 64'd0);
        check("arst_core_nonce",  64'(core_nonce),  64'd0);
        check("arst_core_target", 64'(core_target), 64'd0);
        check("arst_core_header", 64'(core_header == '0), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        // ---------------- Empty range: straight to DONE ----------------
        set_hits(32'd1, 32'd0, 1'b0, 0);
        run_job(32'd10, 32'd9, lat);
        check("empty_done_lat",   64'(lat),        64'd1);
        check("empty_busy",       64'(busy),       64'd0);
        check("empty_core_nonce", 64'(core_nonce), 64'd0);

        // ---------------- Abort in SCAN ----------------
        set_hits(32'd1000, 32'd1099, 1'b0, 0);
        @(posedge clk); #1;
        nonce_start = 32'd1000; nonce_end = 32'd1099; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_pre_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        n_done = 0; n_valid = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done)      n_done++;
            if (res_valid) n_valid++;
        end
        check("abort_no_done",   64'(n_done),      64'd0);
        check("abort_no_result", 64'(n_valid),     64'd0);
        check("abort_dropped",   64'(res_dropped), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
